// File: rtl/mfp_ahb_rojobot_if_pkg.sv
// Shared constants for the Rojobot AHB responder: register offsets, bit positions, FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mfp_ahb_rojobot_if_pkg;

    localparam logic [2:0] REG_BOT_INFO = 3'd0;
    localparam logic [2:0] REG_BOT_CTRL = 3'd1;
    localparam logic [2:0] REG_STATUS   = 3'd2;
    localparam logic [2:0] REG_INT_ACK  = 3'd3;
    localparam logic [2:0] REG_CTRL     = 3'd4;

    localparam int CTRL_IRQ_EN   = 0;
    localparam int CTRL_AUTO_ACK = 1;
    localparam int CTRL_ERR_CLR  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_ACK  = 2'd2
    } bot_state_e;

    function automatic logic [31:0] pack_status(input logic [15:0] cnt, input logic err,
                                                input logic busy, input logic pend,
                                                input logic sync);
        return {cnt, 12'b0, err, busy, pend, sync};
    endfunction

endpackage

// File: rtl/mfp_ahb_rojobot_if_if.sv
// AHB-lite slave-side signal bundle for the Rojobot responder.
// Latency: none (wiring only).
// Backpressure: HREADY is carried here; the slave itself never inserts wait states.
interface mfp_ahb_rojobot_if_if;
    logic        hsel;
    logic [4:0]  haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic        hready;
    logic [31:0] hwdata;
    logic [31:0] hrdata;

    modport master (output hsel, haddr, htrans, hwrite, hready, hwdata, input hrdata);
    modport slave  (input hsel, haddr, htrans, hwrite, hready, hwdata, output hrdata);
endinterface

// File: rtl/mfp_ahb_rojobot_if_fsm.sv
// Update handshake machine: snapshot capture, update counter, ack with timeout and error flag.
// Latency: sync_q high -> PEND one edge; ack request -> ACK one edge.
// Backpressure: H_INT_ACK is held until sync_q falls or the timeout expires.
module mfp_ahb_rojobot_if_fsm
    import mfp_ahb_rojobot_if_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sync_q,
    input  logic [31:0]      i_bot_info,
    input  logic             i_ack_req,
    input  logic             i_auto_ack,
    input  logic             i_irq_en,
    input  logic             i_err_clr,
    output logic [31:0]      o_snapshot,
    output logic [CNT_W-1:0] o_upd_cnt,
    output logic             o_err,
    output logic             o_pending,
    output logic             o_ack_busy,
    output logic             o_int_ack,
    output logic             o_irq
);

    localparam int            TW   = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);

    bot_state_e       r_state;
    bot_state_e       w_next;
    logic [31:0]      r_snapshot;
    logic [CNT_W-1:0] r_upd_cnt;
    logic [TW-1:0]    r_timer;
    logic             r_err;
    logic             w_timeout;

    assign w_timeout = (r_state == S_ACK) && i_sync_q && (r_timer == TMAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_snapshot <= '0;
            r_upd_cnt  <= '0;
            r_timer    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_sync_q) begin
                r_snapshot <= i_bot_info;
                r_upd_cnt  <= r_upd_cnt + CNT_W'(1);
            end
            // Timer restarts every time ACK is entered because it is cleared in every other state.
            r_timer <= (r_state == S_ACK) ? r_timer + TW'(1) : '0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_sync_q) w_next = S_PEND;
            S_PEND: if (i_ack_req || i_auto_ack) w_next = S_ACK;
            S_ACK:  if (!i_sync_q || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign o_snapshot = r_snapshot;
    assign o_upd_cnt  = r_upd_cnt;
    assign o_err      = r_err;
    assign o_pending  = (r_state == S_PEND);
    assign o_ack_busy = (r_state == S_ACK);
    assign o_int_ack  = (r_state == S_ACK);
    assign o_irq      = (r_state == S_PEND) && i_irq_en;

endmodule

// File: rtl/mfp_ahb_rojobot_if.sv
// AHB-lite register front end for the Rojobot update handshake (decode, registers, read mux).
// Latency: zero wait states; read data loaded at end of address phase, writes at end of data phase.
// Backpressure: HREADY low freezes the latched address phase; no new phase is accepted.
module mfp_ahb_rojobot_if
    import mfp_ahb_rojobot_if_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                   i_hclk,
    input  logic                   i_hreset,
    mfp_ahb_rojobot_if_if.slave    ahb,
    input  logic [31:0]            i_h_bot_info,
    input  logic                   i_h_bot_update_sync,
    output logic [7:0]             o_h_bot_ctrl,
    output logic                   o_h_int_ack,
    output logic                   o_bot_irq
);

    logic             r_sync_q;
    logic             r_dph_vld;
    logic             r_dph_wr;
    logic [2:0]       r_dph_addr;
    logic [31:0]      r_hrdata;
    logic [7:0]       r_bot_ctrl;
    logic [1:0]       r_ctrl;

    logic             w_addr_accept;
    logic             w_wr_strobe;
    logic             w_ack_req;
    logic             w_err_clr;
    logic [31:0]      w_rd_data;
    logic [31:0]      w_snapshot;
    logic [CNT_W-1:0] w_upd_cnt;
    logic             w_err;
    logic             w_pending;
    logic             w_ack_busy;
    logic             w_unused;

    assign w_addr_accept = ahb.hsel && ahb.htrans[1] && ahb.hready;
    assign w_wr_strobe   = r_dph_vld && r_dph_wr && ahb.hready;
    assign w_ack_req     = w_wr_strobe && (r_dph_addr == REG_INT_ACK) && ahb.hwdata[0];
    assign w_err_clr     = w_wr_strobe && (r_dph_addr == REG_CTRL) && ahb.hwdata[CTRL_ERR_CLR];
    assign w_unused      = ^{ahb.hwdata[31:8], ahb.haddr[1:0], ahb.htrans[0]};

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_sync_q   <= 1'b0;
            r_dph_vld  <= 1'b0;
            r_dph_wr   <= 1'b0;
            r_dph_addr <= '0;
            r_hrdata   <= '0;
            r_bot_ctrl <= '0;
            r_ctrl     <= '0;
        end else begin
            r_sync_q <= i_h_bot_update_sync;
            if (ahb.hready) begin
                r_dph_vld  <= w_addr_accept;
                r_dph_wr   <= ahb.hwrite;
                r_dph_addr <= ahb.haddr[4:2];
            end
            // Reads sample the registers as they stand before this edge's updates.
            if (w_addr_accept && !ahb.hwrite) begin
                r_hrdata <= w_rd_data;
            end
            if (w_wr_strobe) begin
                case (r_dph_addr)
                    REG_BOT_CTRL: r_bot_ctrl <= ahb.hwdata[7:0];
                    REG_CTRL:     r_ctrl     <= ahb.hwdata[1:0];
                    default:      ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (ahb.haddr[4:2])
            REG_BOT_INFO: w_rd_data = w_snapshot;
            REG_BOT_CTRL: w_rd_data = {24'b0, r_bot_ctrl};
            REG_STATUS:   w_rd_data = pack_status(16'(w_upd_cnt), w_err, w_ack_busy,
                                                  w_pending, r_sync_q);
            REG_CTRL:     w_rd_data = {30'b0, r_ctrl};
            default:      w_rd_data = '0;
        endcase
    end

    mfp_ahb_rojobot_if_fsm #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_fsm (
        .i_clk      (i_hclk),
        .i_rst      (i_hreset),
        .i_sync_q   (r_sync_q),
        .i_bot_info (i_h_bot_info),
        .i_ack_req  (w_ack_req),
        .i_auto_ack (r_ctrl[CTRL_AUTO_ACK]),
        .i_irq_en   (r_ctrl[CTRL_IRQ_EN]),
        .i_err_clr  (w_err_clr),
        .o_snapshot (w_snapshot),
        .o_upd_cnt  (w_upd_cnt),
        .o_err      (w_err),
        .o_pending  (w_pending),
        .o_ack_busy (w_ack_busy),
        .o_int_ack  (o_h_int_ack),
        .o_irq      (o_bot_irq)
    );

    assign ahb.hrdata   = r_hrdata;
    assign o_h_bot_ctrl = r_bot_ctrl;

endmodule

// File: tb/tb_mfp_ahb_rojobot_if.sv
// Directed-plus-random bench for the Rojobot AHB responder with a transaction-level model.
// The counter is built 8 bits wide here so the wrap boundary is reachable in a short run.
module tb_mfp_ahb_rojobot_if;

    localparam int TB_CNT_W = 8;
    localparam int TB_TO    = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bot_info;
    logic        bot_sync;
    logic [7:0]  h_bot_ctrl;
    logic        int_ack;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model: update count, last captured snapshot, error flag.
    int          m_cnt;
    logic [31:0] m_snap;
    logic        m_err;

    always #10 clk = ~clk;

    mfp_ahb_rojobot_if_if bus ();

    mfp_ahb_rojobot_if #(
        .ACK_TIMEOUT (TB_TO),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .i_hclk              (clk),
        .i_hreset            (rst),
        .ahb                 (bus),
        .i_h_bot_info        (bot_info),
        .i_h_bot_update_sync (bot_sync),
        .o_h_bot_ctrl        (h_bot_ctrl),
        .o_h_int_ack         (int_ack),
        .o_bot_irq           (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int cnt, input logic err, input logic busy,
                                               input logic pend, input logic sync);
        logic [15:0] c;
        c = 16'(cnt % (1 << TB_CNT_W));
        return {c, 12'b0, err, busy, pend, sync};
    endfunction

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b1; bus.haddr = a;
        tick();
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hwdata = d;
        tick();
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b0; bus.haddr = a;
        tick();
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        d = bus.hrdata;
    endtask

    task automatic wait_ack(input logic val, input string tag, output int n);
        n = 0;
        while (int_ack !== val && n < 300) begin
            tick();
            n++;
        end
        check(tag, {31'b0, int_ack}, {31'b0, val});
    endtask

    // One update acknowledged by AUTO_ACK, with the flag dropped as soon as ack is seen.
    task automatic auto_handshake();
        int n;
        logic [31:0] info;
        info = $urandom;
        bot_info = info;
        bot_sync = 1'b1;
        wait_ack(1'b1, "auto_ack_rise", n);
        bot_sync = 1'b0;
        bot_info = $urandom;
        wait_ack(1'b0, "auto_ack_fall", n);
        m_cnt++;
        m_snap = info;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] v;
        logic [31:0] info;
        logic        saw_irq;
        logic        en;
        int          n;

        rst = 1'b1;
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hready = 1'b1;
        bus.haddr = '0; bus.hwdata = '0;
        bot_info = $urandom;
        bot_sync = 1'b0;
        m_cnt = 0; m_snap = '0; m_err = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_bot_ctrl", {24'b0, h_bot_ctrl}, 32'h0);
        check("rst_int_ack", {31'b0, int_ack}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_hrdata", bus.hrdata, 32'h0);
        bus_rd(5'h08, rd); check("rst_status", rd, 32'h0);
        bus_rd(5'h00, rd); check("rst_bot_info", rd, 32'h0);

        // Basic handshake with IRQ_EN
        bus_wr(5'h10, 32'h1);
        bot_info = 32'h11223344;
        bot_sync = 1'b1;
        tick(); check("irq_lat1", {31'b0, irq}, 32'h0);
        tick(); check("irq_lat2", {31'b0, irq}, 32'h1);
        m_cnt++; m_snap = 32'h11223344;
        bot_info = $urandom;
        bus_rd(5'h00, rd); check("pend_snapshot", rd, m_snap);
        bus_rd(5'h08, rd); check("pend_status", rd, exp_status(m_cnt, 1'b0, 1'b0, 1'b1, 1'b1));
        bus_wr(5'h0C, 32'h1);
        check("int_ack_after_wr", {31'b0, int_ack}, 32'h1);
        check("irq_off_in_ack", {31'b0, irq}, 32'h0);
        bot_sync = 1'b0;
        wait_ack(1'b0, "ack_release", n);
        bus_rd(5'h08, rd); check("idle_status", rd, exp_status(m_cnt, 1'b0, 1'b0, 1'b0, 1'b0));

        // STATUS read on the IDLE->PEND edge returns pre-update values
        bot_sync = 1'b1;
        tick();
        bus_rd(5'h08, rd); check("status_pre_update", rd, exp_status(m_cnt, 1'b0, 1'b0, 1'b0, 1'b1));
        m_cnt++; m_snap = bot_info;
        bus_wr(5'h0C, 32'h1);
        bot_sync = 1'b0;
        wait_ack(1'b0, "ack_release2", n);

        // AUTO_ACK with IRQ disabled: ack without a bus write, no interrupt
        bus_wr(5'h10, 32'h2);
        info = $urandom; bot_info = info; bot_sync = 1'b1;
        saw_irq = 1'b0; n = 0;
        while (int_ack !== 1'b1 && n < 50) begin
            tick(); n++;
            if (irq === 1'b1) saw_irq = 1'b1;
        end
        check("auto_ack_latency", n, 3);
        check("auto_no_irq", {31'b0, saw_irq}, 32'h0);
        m_cnt++; m_snap = info;

        // Timeout: flag held high for the whole ACK phase
        n = 0;
        while (int_ack === 1'b1 && n < 200) begin
            tick(); n++;
        end
        check("ack_timeout_len", n, TB_TO + 1 - 1);
        bot_sync = 1'b0;
        m_err = 1'b1;
        m_cnt++;  // the flag was still high when IDLE was re-entered
        repeat (6) tick();
        check("post_timeout_ack", {31'b0, int_ack}, 32'h0);
        bus_rd(5'h08, rd); check("timeout_err", rd, exp_status(m_cnt, m_err, 1'b0, 1'b0, 1'b0));
        bus_wr(5'h10, 32'h4);
        m_err = 1'b0;
        bus_rd(5'h08, rd); check("err_cleared", rd, exp_status(m_cnt, m_err, 1'b0, 1'b0, 1'b0));
        bus_rd(5'h10, rd); check("ctrl_selfclr", rd, 32'h0);

        // BOT_CTRL writes, read-back, unmapped and write-only offsets
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 32'h000000A5 : $urandom;
            bus_wr(5'h04, v);
            check("bot_ctrl_out", {24'b0, h_bot_ctrl}, {24'b0, v[7:0]});
            bus_rd(5'h04, rd); check("bot_ctrl_rd", rd, {24'b0, v[7:0]});
        end
        bus_wr(5'h18, $urandom);
        check("unmapped_wr_ignored", {24'b0, h_bot_ctrl}, {24'b0, v[7:0]});
        bus_rd(5'h14, rd); check("unmapped_rd", rd, 32'h0);
        bus_rd(5'h0C, rd); check("int_ack_rd", rd, 32'h0);
        bus_wr(5'h0C, 32'h1);
        check("int_ack_idle_ignored", {31'b0, int_ack}, 32'h0);
        tick();
        check("int_ack_idle_ignored2", {31'b0, int_ack}, 32'h0);
        bus_rd(5'h08, rd); check("idle_status2", rd, exp_status(m_cnt, 1'b0, 1'b0, 1'b0, 1'b0));

        // HREADY low: the address phase must not be taken
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b1; bus.haddr = 5'h04;
        bus.hready = 1'b0;
        tick();
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hready = 1'b1;
        bus.hwdata = ~v;
        tick(); tick();
        check("hready_low_no_wr", {24'b0, h_bot_ctrl}, {24'b0, v[7:0]});

        // Counter wrap
        bus_wr(5'h10, 32'h2);
        while ((m_cnt % (1 << TB_CNT_W)) != ((1 << TB_CNT_W) - 1)) auto_handshake();
        bus_rd(5'h08, rd); check("cnt_max", rd, exp_status(m_cnt, 1'b0, 1'b0, 1'b0, 1'b0));
        auto_handshake();
        bus_rd(5'h08, rd); check("cnt_wrap", rd, exp_status(m_cnt, 1'b0, 1'b0, 1'b0, 1'b0));
        check("cnt_wrap_zero", rd[31:16], 32'h0);
        bus_rd(5'h00, rd); check("wrap_snapshot", rd, m_snap);

        // Reset while acknowledging; the still-high flag is captured again afterwards
        bot_info = $urandom; bot_sync = 1'b1;
        wait_ack(1'b1, "pre_reset_ack", n);
        rst = 1'b1;
        tick();
        check("reset_drops_ack", {31'b0, int_ack}, 32'h0);
        check("reset_bot_ctrl", {24'b0, h_bot_ctrl}, 32'h0);
        rst = 1'b0;
        m_cnt = 0; m_err = 1'b0;
        tick(); tick();
        m_cnt++; m_snap = bot_info;
        bus_rd(5'h08, rd); check("recapture_status", rd, exp_status(m_cnt, 1'b0, 1'b0, 1'b1, 1'b1));
        bus_rd(5'h00, rd); check("recapture_snap", rd, m_snap);
        bus_wr(5'h0C, 32'h1);
        bot_sync = 1'b0;
        wait_ack(1'b0, "recapture_release", n);

        // Random handshakes acknowledged by software
        for (int i = 0; i < 8; i++) begin
            en = 1'($urandom_range(0, 1));
            bus_wr(5'h10, {31'b0, en});
            info = $urandom; bot_info = info; bot_sync = 1'b1;
            tick(); tick();
            m_cnt++; m_snap = info;
            check("rnd_irq", {31'b0, irq}, {31'b0, en});
            repeat ($urandom_range(0, 4)) begin
                bot_info = $urandom;
                tick();
            end
            bus_rd(5'h00, rd); check("rnd_snapshot", rd, m_snap);
            bus_wr(5'h0C, 32'h1);
            check("rnd_ack", {31'b0, int_ack}, 32'h1);
            bot_sync = 1'b0;
            wait_ack(1'b0, "rnd_release", n);
            bus_rd(5'h08, rd); check("rnd_status", rd, exp_status(m_cnt, 1'b0, 1'b0, 1'b0, 1'b0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
